// File: rtl/lvpecl_serial_tx_pkg.sv
// lvpecl_serial_tx_pkg: shared state encoding, line level and width helper
package lvpecl_serial_tx_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic IDLE_LEVEL = 1'b1;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/diff_pair_reg.sv
// diff_pair_reg: registered complementary driver, resets to mark
module diff_pair_reg
  import lvpecl_serial_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic o,
  output logic ob
);
  always_ff @(posedge clk) begin
    o <= rst ? IDLE_LEVEL : d;
    ob <= rst ? ~IDLE_LEVEL : ~d;
  end
endmodule

// File: rtl/lvpecl_serial_tx.sv
// lvpecl_serial_tx: framed start/data/stop serializer onto a registered differential pair
module lvpecl_serial_tx
  import lvpecl_serial_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             BUSY,
  output logic             O,
  output logic             OB
);
  localparam int CW = cnt_width(DIV);
  localparam int IW = cnt_width(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic armed, bit_end, last_bit, accept, line_n;
  assign bit_end = cnt == CW'(DIV - 1);
  assign last_bit = idx == IW'(WIDTH - 1);
  assign READY = (state == S_IDLE && armed) || (state == S_STOP && bit_end);
  assign BUSY = state != S_IDLE;
  assign accept = VALID && READY;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      armed <= 1'b1;
    end
  end
  // line_n is the level of the next cycle, so the output flop lands it on time
  always_comb begin
    state_n = state;
    cnt_n = (state == S_IDLE || bit_end) ? '0 : cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    if (accept) begin
      state_n = S_START;
      shift_n = DATA;
      idx_n = '0;
      cnt_n = '0;
    end else if (bit_end && state == S_START) begin
      state_n = S_DATA;
    end else if (bit_end && state == S_DATA) begin
      shift_n = shift >> 1;
      idx_n = last_bit ? '0 : idx + 1'b1;
      state_n = last_bit ? S_STOP : S_DATA;
    end else if (bit_end && state == S_STOP) begin
      state_n = S_IDLE;
    end
    line_n = state_n == S_START ? 1'b0 : state_n == S_DATA ? shift_n[0] : IDLE_LEVEL;
  end
  diff_pair_reg u_pair (
    .clk(CLK),
    .rst(RST),
    .d(line_n),
    .o(O),
    .ob(OB)
  );
endmodule

// File: tb/tb_lvpecl_serial_tx.sv
// tb_lvpecl_serial_tx: frame-level queue model checked every cycle plus literal waveforms
module tb_lvpecl_serial_tx;
  typedef logic lq_t[$];
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, valid = 1'b1, ready, busy, o, ob;
  logic [7:0] data = 8'hA5;
  logic rst2 = 1'b1, valid2 = 1'b0, ready2, busy2, o2, ob2;
  logic [0:0] data2 = 1'b0;

  int n_cmp = 0, n_bad = 0;

  lvpecl_serial_tx #(.WIDTH(8), .DIV(4)) u1 (
    .CLK(clk), .RST(rst), .DATA(data), .VALID(valid),
    .READY(ready), .BUSY(busy), .O(o), .OB(ob)
  );
  lvpecl_serial_tx #(.WIDTH(1), .DIV(1)) u2 (
    .CLK(clk), .RST(rst2), .DATA(data2), .VALID(valid2),
    .READY(ready2), .BUSY(busy2), .O(o2), .OB(ob2)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // A frame is start(0), data LSB first, stop(1), each held d cycles
  function automatic lq_t frame(input int w, input int d, input logic [7:0] v);
    lq_t r;
    logic lvl;
    for (int b = 0; b < w + 2; b++) begin
      lvl = (b == 0) ? 1'b0 : (b == w + 1) ? 1'b1 : v[b-1];
      for (int k = 0; k < d; k++) r.push_back(lvl);
    end
    return r;
  endfunction

  lq_t q1, q2;
  logic arm1 = 1'b0, arm2 = 1'b0, go1 = 1'b0, go2 = 1'b0;

  always @(posedge clk) begin
    logic acc;
    if (rst) begin
      q1.delete();
      arm1 = 1'b0;
      go1 = 1'b1;
    end else begin
      acc = valid && arm1 && q1.size() <= 1;
      if (q1.size() != 0) void'(q1.pop_front());
      if (acc) q1 = {q1, frame(8, 4, data)};
      arm1 = 1'b1;
    end
    if (rst2) begin
      q2.delete();
      arm2 = 1'b0;
      go2 = 1'b1;
    end else begin
      acc = valid2 && arm2 && q2.size() <= 1;
      if (q2.size() != 0) void'(q2.pop_front());
      if (acc) q2 = {q2, frame(1, 1, {7'd0, data2})};
      arm2 = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic e;
    if (go1) begin
      e = q1.size() != 0 ? q1[0] : 1'b1;
      chk("m_o", o, e);
      chk("m_ob", ob, ~e);
      chk("m_ready", ready, arm1 && q1.size() <= 1);
      chk("m_busy", busy, q1.size() != 0);
    end
    if (go2) begin
      e = q2.size() != 0 ? q2[0] : 1'b1;
      chk("m2_o", o2, e);
      chk("m2_ob", ob2, ~e);
      chk("m2_ready", ready2, arm2 && q2.size() <= 1);
      chk("m2_busy", busy2, q2.size() != 0);
    end
  end

  task automatic send(input logic [7:0] d, input logic keep);
    @(posedge clk); #1;
    valid = 1'b1;
    data = d;
    @(posedge clk); #1;
    valid = keep;
  endtask

  // Compare n bits of O (pat[0] first) against literals, optionally toggling VALID
  task automatic capture(input string nm, input logic [19:0] pat, input int n, input int v_on, input int v_off);
    for (int i = 0; i < n * 4; i++) begin
      @(negedge clk);
      if (i == v_on) begin
        valid = 1'b1;
        data = 8'hFF;
      end
      if (i == v_off) valid = 1'b0;
      chk(nm, o, pat[i/4]);
      if (i == v_on) chk("ready_mid", ready, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_o", o, 1'b1);
    @(negedge clk);
    chk("rel_ready", ready, 1'b1);
    send(8'hA5, 1'b0);
    capture("a5", 20'b1101001010, 10, -1, -1);
    @(negedge clk);
    chk("idle_o", o, 1'b1);
    send(8'h00, 1'b1);
    data = 8'hFF;
    capture("b2b", 20'b11111111101000000000, 20, -1, 40);
    send(8'h5A, 1'b0);
    capture("ign", 20'b1010110100, 10, 10, 14);
    send(8'hA5, 1'b0);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_o", o, 1'b1);
    chk("abort_ob", ob, 1'b0);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b0;
    send(8'h3C, 1'b0);
    capture("3c", 20'b1001111000, 10, -1, -1);
    @(negedge clk);
    rst2 = 1'b0;
    @(posedge clk); #1;
    valid2 = 1'b1;
    data2 = 1'b0;
    @(posedge clk); #1;
    valid2 = 1'b0;
    @(negedge clk);
    chk("d1_b0", o2, 1'b0);
    @(negedge clk);
    chk("d1_b1", o2, 1'b0);
    @(negedge clk);
    chk("d1_stop", o2, 1'b1);
    chk("d1_ready", ready2, 1'b1);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
